// File: rtl/irda_tx_sched.sv
// IrDA transmit-path scheduler: grants the TX pad frame by frame, inserts periodic
// Serial Interaction Pulses in MIR/FIR and holds the pad idle for a guard time on mode changes.
//
//   state     | meaning
//   ST_IDLE   | pad idle, arbitrating mode change > SIP > frame request
//   ST_GUARD  | new mode applied, pad held off for GUARD_CYCLES
//   ST_ACTIVE | encoder owns the pad until tx_done
//   ST_SIP    | SIP pulse on the pad for SIP_WIDTH cycles
module irda_tx_sched #(
   parameter int SIP_PERIOD   = 40000000,
   parameter int SIP_WIDTH    = 128,
   parameter int GUARD_CYCLES = 64,
   parameter int CNT_W        = 26
) (
   input  logic       clk,
   input  logic       wb_rst_i,
   input  logic [1:0] mode_req,
   input  logic       mode_wr,
   input  logic       sip_en,
   input  logic       tx_req,
   input  logic       tx_done,
   output logic       tx_select,
   output logic       fast_mode,
   output logic       mir_mode,
   output logic       tx_grant,
   output logic       sip_gen_o,
   output logic       mode_busy
);

   localparam int TMR_MAX = (SIP_WIDTH > GUARD_CYCLES) ? SIP_WIDTH : GUARD_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_ACTIVE, ST_SIP} state_t;

   state_t           state;
   logic [CNT_W-1:0] sip_cnt;
   logic [TMR_W-1:0] tmr;
   logic             pend_vld;
   logic [1:0]       pend_mode;
   logic [1:0]       req_mode;
   logic [1:0]       cur_mode;
   logic [1:0]       tgt_mode;
   logic             sip_due;
   logic             tmr_zero;
   logic             frame_end;
   logic             sip_end;

   // Mode encoding 00 SIR, 01 MIR, 10 FIR; the reserved code folds onto SIR.
   assign req_mode  = (mode_req == 2'b11) ? 2'b00 : mode_req;
   assign cur_mode  = {fast_mode & ~mir_mode, mir_mode};
   assign tgt_mode  = mode_wr ? req_mode : (pend_vld ? pend_mode : cur_mode);
   assign sip_due   = (sip_cnt == CNT_W'(SIP_PERIOD - 1));
   assign tmr_zero  = (tmr == '0);
   assign frame_end = (state == ST_ACTIVE) && tx_done;
   assign sip_end   = (state == ST_SIP) && tmr_zero;

   always_ff @(posedge clk) begin
      if (wb_rst_i) begin
         state     <= ST_IDLE;
         sip_cnt   <= '0;
         tmr       <= '0;
         pend_vld  <= 1'b0;
         pend_mode <= 2'b00;
         tx_select <= 1'b0;
         fast_mode <= 1'b0;
         mir_mode  <= 1'b0;
         tx_grant  <= 1'b0;
         sip_gen_o <= 1'b0;
         mode_busy <= 1'b0;
      end else begin
         // Saturates at SIP_PERIOD-1 so a missed SIP stays due until served or reloaded.
         if (frame_end || sip_end || !(fast_mode && sip_en))
            sip_cnt <= '0;
         else if (!sip_due)
            sip_cnt <= sip_cnt + 1'b1;

         case (state)
            ST_IDLE: begin
               pend_vld  <= 1'b0;
               mode_busy <= (tgt_mode != cur_mode);
               if (tgt_mode != cur_mode) begin
                  state     <= ST_GUARD;
                  fast_mode <= (tgt_mode != 2'b00);
                  mir_mode  <= (tgt_mode == 2'b01);
                  tmr       <= TMR_W'(GUARD_CYCLES - 1);
               end else if (sip_due) begin
                  state     <= ST_SIP;
                  tmr       <= TMR_W'(SIP_WIDTH - 1);
                  tx_select <= 1'b1;
                  sip_gen_o <= 1'b1;
               end else if (tx_req) begin
                  state     <= ST_ACTIVE;
                  tx_select <= 1'b1;
                  tx_grant  <= 1'b1;
               end
            end
            ST_GUARD: begin
               if (mode_wr) begin
                  fast_mode <= (req_mode != 2'b00);
                  mir_mode  <= (req_mode == 2'b01);
                  tmr       <= TMR_W'(GUARD_CYCLES - 1);
               end else if (tmr_zero) begin
                  state     <= ST_IDLE;
                  mode_busy <= 1'b0;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (mode_wr) begin
                  pend_vld  <= (req_mode != cur_mode);
                  pend_mode <= req_mode;
                  mode_busy <= (req_mode != cur_mode);
               end
               if (tx_done) begin
                  state     <= ST_IDLE;
                  tx_select <= 1'b0;
                  tx_grant  <= 1'b0;
               end
            end
            ST_SIP: begin
               if (mode_wr) begin
                  pend_vld  <= (req_mode != cur_mode);
                  pend_mode <= req_mode;
                  mode_busy <= (req_mode != cur_mode);
               end
               if (tmr_zero) begin
                  state     <= ST_IDLE;
                  tx_select <= 1'b0;
                  sip_gen_o <= 1'b0;
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_irda_tx_sched.sv
// Bench for irda_tx_sched: a cycle reference model predicts every output vector,
// a monitor compares it against the DUT; directed timing checks cover the key sequences.
module tb_irda_tx_sched;

   localparam int PER = 1000;
   localparam int W   = 8;
   localparam int G   = 64;

   localparam int PH_IDLE   = 0;
   localparam int PH_GUARD  = 1;
   localparam int PH_ACTIVE = 2;
   localparam int PH_SIP    = 3;

   logic       clk = 1'b0;
   logic       wb_rst_i = 1'b1;
   logic [1:0] mode_req = 2'b00;
   logic       mode_wr = 1'b0;
   logic       sip_en = 1'b0;
   logic       tx_req = 1'b0;
   logic       tx_done = 1'b0;
   logic       tx_select, fast_mode, mir_mode, tx_grant, sip_gen_o, mode_busy;

   irda_tx_sched #(
      .SIP_PERIOD  (PER),
      .SIP_WIDTH   (W),
      .GUARD_CYCLES(G),
      .CNT_W       (26)
   ) dut (
      .clk      (clk),
      .wb_rst_i (wb_rst_i),
      .mode_req (mode_req),
      .mode_wr  (mode_wr),
      .sip_en   (sip_en),
      .tx_req   (tx_req),
      .tx_done  (tx_done),
      .tx_select(tx_select),
      .fast_mode(fast_mode),
      .mir_mode (mir_mode),
      .tx_grant (tx_grant),
      .sip_gen_o(sip_gen_o),
      .mode_busy(mode_busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc_n = 0;
   logic [5:0] exp_q[$];

   // Reference model: phase, cycles left in a timed phase, mode (0 SIR,1 MIR,2 FIR),
   // pending mode (-1 none) and cycles elapsed toward the next SIP.
   int m_phase = PH_IDLE, m_left = 0, m_mode = 0, m_pend = -1, m_age = 0;
   bit m_busy = 1'b0;

   task automatic model_step(input bit rst, input bit wr, input logic [1:0] req,
                             input bit sen, input bit treq, input bit tdone);
      int norm, tgt, nxt_age;
      bit due, reload;
      if (rst) begin
         m_phase = PH_IDLE; m_mode = 0; m_pend = -1; m_age = 0; m_left = 0; m_busy = 1'b0;
         return;
      end
      norm    = (req == 2'd3) ? 0 : int'(req);
      due     = (m_age == PER - 1);
      reload  = (m_phase == PH_ACTIVE && tdone) || (m_phase == PH_SIP && m_left == 1) ||
                !(m_mode != 0 && sen);
      nxt_age = reload ? 0 : (due ? m_age : m_age + 1);
      case (m_phase)
         PH_IDLE: begin
            tgt    = wr ? norm : ((m_pend >= 0) ? m_pend : m_mode);
            m_pend = -1;
            if (tgt != m_mode) begin
               m_phase = PH_GUARD; m_mode = tgt; m_left = G;
            end else if (due) begin
               m_phase = PH_SIP; m_left = W;
            end else if (treq) begin
               m_phase = PH_ACTIVE;
            end
         end
         PH_GUARD: begin
            if (wr) begin
               m_mode = norm; m_left = G;
            end else if (m_left == 1) m_phase = PH_IDLE;
            else m_left--;
         end
         PH_ACTIVE: begin
            if (wr) m_pend = (norm != m_mode) ? norm : -1;
            if (tdone) m_phase = PH_IDLE;
         end
         default: begin
            if (wr) m_pend = (norm != m_mode) ? norm : -1;
            if (m_left == 1) m_phase = PH_IDLE;
            else m_left--;
         end
      endcase
      m_age  = nxt_age;
      m_busy = (m_phase == PH_GUARD) || (m_pend >= 0);
   endtask

   function automatic logic [5:0] model_out();
      logic [5:0] v;
      v[5] = (m_phase == PH_ACTIVE) || (m_phase == PH_SIP);
      v[4] = (m_mode != 0);
      v[3] = (m_mode == 1);
      v[2] = (m_phase == PH_ACTIVE);
      v[1] = (m_phase == PH_SIP);
      v[0] = m_busy;
      return v;
   endfunction

   // One clock of stimulus; DUT outputs read right after return belong to this cycle.
   task automatic cyc(input bit rst, input bit wr, input logic [1:0] req,
                      input bit sen, input bit treq, input bit tdone);
      @(negedge clk);
      wb_rst_i = rst; mode_wr = wr; mode_req = req; sip_en = sen; tx_req = treq; tx_done = tdone;
      model_step(rst, wr, req, sen, treq, tdone);
      exp_q.push_back(model_out());
      cyc_n++;
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   initial begin : monitor
      logic [5:0] e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {tx_select, fast_mode, mir_mode, tx_grant, sip_gen_o, mode_busy};
            n_chk++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL outputs at %0t {sel,fast,mir,grant,sip,busy}: got %b, expected %b",
                        $time, a, e);
            end
         end
      end
   end

   initial begin : driver
      int gk, r1, r2, wid, bad, t, dk, seen;
      bit prev, sen, rnd_rst, rnd_wr;
      repeat (3) cyc(1, 0, 2'b00, 0, 0, 0);

      // SIR frame grant and release
      cyc(0, 0, 2'b00, 0, 1, 0);
      repeat (4) cyc(0, 0, 2'b00, 0, 1, 0);
      cyc(0, 0, 2'b00, 0, 0, 1);
      repeat (3) cyc(0, 0, 2'b00, 0, 0, 1);

      // Switch to FIR; request raised during guard is granted on cycle 66
      cyc(0, 1, 2'b10, 0, 0, 0);
      gk = -1;
      for (int k = 1; k <= 200 && gk < 0; k++) begin
         cyc(0, 0, 2'b00, 0, 1, 0);
         if (tx_grant) gk = k;
      end
      check("grant_after_guard", gk, G + 2);
      cyc(0, 0, 2'b00, 0, 0, 1);
      repeat (2) cyc(0, 0, 2'b00, 0, 0, 0);

      // MIR with SIP enabled, idle: pulse width and spacing
      cyc(0, 1, 2'b01, 1, 0, 0);
      r1 = -1; r2 = -1; wid = 0; bad = 0; prev = 1'b0;
      for (int k = 1; k <= 2300; k++) begin
         cyc(0, 0, 2'b00, 1, 0, 0);
         if (sip_gen_o && !prev) begin
            if (r1 < 0) r1 = k;
            else if (r2 < 0) r2 = k;
         end
         if (sip_gen_o && r2 < 0) wid++;
         if (sip_gen_o && !tx_select) bad++;
         prev = sip_gen_o;
      end
      check("sip_width", wid, W);
      check("sip_spacing", r2 - r1, PER + W);
      check("sip_without_tx_select", bad, 0);

      // Long frame swallows the due SIP; next SIP comes PER edges after tx_done
      gk = -1; bad = 0;
      for (int k = 1; k <= 1200; k++) begin
         cyc(0, 0, 2'b00, 1, 1, 0);
         if (tx_grant && gk < 0) gk = k;
         if (gk >= 0 && sip_gen_o) bad++;
      end
      check("frame_granted", int'(gk >= 0 && gk < 100), 1);
      check("sip_during_frame", bad, 0);
      cyc(0, 0, 2'b00, 1, 0, 1);
      t = cyc_n; dk = -1;
      for (int k = 1; k <= 1200 && dk < 0; k++) begin
         cyc(0, 0, 2'b00, 1, 0, 0);
         if (sip_gen_o) dk = cyc_n - t;
      end
      check("sip_after_frame_end", dk, PER + 1);
      repeat (W + 2) cyc(0, 0, 2'b00, 1, 0, 0);

      // Reserved code acts as SIR, then FIR, then a MIR request deferred by a frame
      cyc(0, 1, 2'b11, 1, 0, 0);
      repeat (G + 4) cyc(0, 0, 2'b00, 1, 0, 0);
      check("reserved_is_sir", int'(fast_mode), 0);
      cyc(0, 1, 2'b10, 0, 0, 0);
      repeat (G + 4) cyc(0, 0, 2'b00, 0, 0, 0);
      repeat (5) cyc(0, 0, 2'b00, 0, 1, 0);
      cyc(0, 1, 2'b01, 0, 1, 0);
      repeat (20) cyc(0, 0, 2'b00, 0, 0, 0);
      check("mode_held_in_frame", int'({fast_mode, mir_mode}), 2);
      cyc(0, 0, 2'b00, 0, 0, 1);
      repeat (G + 6) cyc(0, 0, 2'b00, 0, 0, 0);
      check("mir_after_frame", int'({fast_mode, mir_mode}), 3);

      // Reset in the middle of a SIP pulse
      seen = 0;
      for (int k = 1; k <= 1200 && seen == 0; k++) begin
         cyc(0, 0, 2'b00, 1, 0, 0);
         if (sip_gen_o) seen = 1;
      end
      check("sip_seen_before_reset", seen, 1);
      repeat (3) cyc(0, 0, 2'b00, 1, 0, 0);
      cyc(1, 0, 2'b00, 1, 0, 0);
      cyc(0, 0, 2'b00, 1, 0, 0);
      check("reset_clears_outputs",
            int'({tx_select, fast_mode, mir_mode, tx_grant, sip_gen_o, mode_busy}), 0);

      // Randomized traffic
      sen = 1'b1;
      for (int k = 0; k < 15000; k++) begin
         rnd_rst = ($urandom_range(0, 1999) == 0);
         rnd_wr  = ($urandom_range(0, 249) == 0);
         if ($urandom_range(0, 999) == 0) sen = ~sen;
         cyc(rnd_rst, rnd_wr, 2'($urandom_range(0, 3)), sen,
             $urandom_range(0, 2) != 0, $urandom_range(0, 49) == 0);
      end
      repeat (3) cyc(0, 0, 2'b00, 0, 0, 0);
      @(posedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
